// File: rtl/b_fsub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding. Code 2'd3 is unused. If the state register
// ever holds it, the FSM returns to S_IDLE.
package b_fsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/b_fsub_bit.sv
// Combinational 1-bit full subtractor: a - x - bi -> difference d, borrow bo.
// Ports:
//   a, x  in   operand bits
//   bi    in   borrow in
//   d     out  difference bit
//   bo    out  borrow out
module b_fsub_bit (
    input  logic a,
    input  logic x,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = a ^ x ^ bi;
        // Borrow is produced when x > a, or when a == x and a borrow comes in.
        bo = (~a & x) | (~(a ^ x) & bi);
    end

endmodule

// File: rtl/b_fsub_serial.sv
// Bit-serial WIDTH-bit subtractor: y = a - x - bin (mod 2^WIDTH).
// The block processes one bit per clock through a single b_fsub_bit cell, LSB first.
// Handshake: start is accepted in IDLE or DONE. busy is high during the WIDTH RUN cycles.
// done pulses for one cycle when the result lands.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         request; a, x and bin are captured on the accepting edge
//   a, x, bin     minuend, subtrahend and borrow-in
//   busy, done    status (state decodes, never high together)
//   y, bout       registered difference and borrow-out; held until the next completion
module b_fsub_serial
    import b_fsub_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             bout
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, x_sh, r_sh;
    logic [CNTW-1:0]  cnt;
    logic             brw;
    logic             d, bo;
    logic             accept, last;

    b_fsub_bit u_bit (
        .a  (a_sh[0]),
        .x  (x_sh[0]),
        .bi (brw),
        .d  (d),
        .bo (bo)
    );

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (state == S_RUN) && (cnt == CNTW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last ? S_DONE : S_RUN;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state register, so they are glitch-free and one-hot.
    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    // Datapath: operand shifters, result shifter, borrow FF, bit counter, result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            x_sh <= '0;
            r_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
            y    <= '0;
            bout <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            x_sh <= x;
            brw  <= bin;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sh <= a_sh >> 1;
            x_sh <= x_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            brw  <= bo;
            cnt  <= cnt + 1'b1;
            // On the last bit, the current d is not in r_sh yet, so fold it in directly.
            if (last) begin
                y    <= {d, r_sh[WIDTH-1:1]};
                bout <= bo;
            end
        end
    end

endmodule

// File: tb/tb_b_fsub_serial.sv
module tb_b_fsub_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, x;
    logic         bin;
    logic         busy, done;
    logic [W-1:0] y;
    logic         bout;

    int checks = 0;
    int errors = 0;

    b_fsub_serial #(.WIDTH(W), .CNTW(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .x     (x),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s obs=%0h want=%0h", tag, obs, want);
        end
    endtask

    // Reference model: plain integer subtraction. The borrow is the sign of the true difference.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rx, input logic rb);
        int diff;
        logic [W-1:0] ry;
        diff = int'(ra) - int'(rx) - int'(rb);
        ry   = W'((diff + (1 << (W + 1))) % (1 << W));
        return {diff < 0, ry};
    endfunction

    // One operation. If mid is set, the task pulses start and scrambles the operands
    // during RUN. The result must not change, and no extra done may appear.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tx, input logic tbin,
                          input bit mid, input string tag);
        logic [W:0] want;
        bit seen;
        int n;
        want = ref_sub(ta, tx, tbin);
        @(negedge clk);
        a = ta; x = tx; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        chk({tag, "_done_off"}, done, 0);
        if (mid) begin
            a = ~ta; x = ~tx; bin = ~tbin; start = 1'b1;
        end
        seen = 0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && done) chk({tag, "_busy_done_excl"}, 1, 0);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_latency"}, n, W);
            chk({tag, "_y"}, y, want[W-1:0]);
            chk({tag, "_bout"}, bout, want[W]);
        end
        if (mid) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk({tag, "_no_extra_done"}, done, 0);
                chk({tag, "_y_hold"}, {bout, y}, want);
            end
        end
    endtask

    initial begin
        logic [W:0] want;
        int last_done, cyc, ndone;
        bit ok;
        logic [W-1:0] ops_a [3];
        logic [W-1:0] ops_x [3];
        logic         ops_b [3];

        rst = 1'b1; start = 1'b0; a = '0; x = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_bout", bout, 0);
        rst = 1'b0;

        // Directed cases
        run_op(4'b1010, 4'b1111, 1'b0, 0, "t1");
        run_op(4'b0010, 4'b1100, 1'b1, 0, "t2a");
        run_op(4'b1010, 4'b0001, 1'b0, 0, "t2b");
        run_op(4'b1010, 4'b0011, 1'b1, 1, "t3_mid");
        run_op(4'b0000, 4'b1111, 1'b1, 0, "wrap");
        run_op(4'b0110, 4'b0110, 1'b0, 0, "ident");

        // Result holds through IDLE
        want = ref_sub(4'b0110, 4'b0110, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle_hold", {bout, y}, want);

        // Back-to-back with start held high; operands change as each done appears
        ops_a[0] = 4'd9;  ops_x[0] = 4'd3;  ops_b[0] = 1'b0;
        ops_a[1] = 4'd2;  ops_x[1] = 4'd7;  ops_b[1] = 1'b1;
        ops_a[2] = 4'd15; ops_x[2] = 4'd14; ops_b[2] = 1'b1;
        @(negedge clk);
        a = ops_a[0]; x = ops_x[0]; bin = ops_b[0]; start = 1'b1;
        ndone = 0; last_done = 0;
        for (cyc = 1; cyc <= 40 && ndone < 3; cyc++) begin
            @(negedge clk);
            if (done) begin
                want = ref_sub(ops_a[ndone], ops_x[ndone], ops_b[ndone]);
                chk("b2b_y", {bout, y}, want);
                chk("b2b_busy_low", busy, 0);
                if (ndone > 0) chk("b2b_interval", cyc - last_done, W + 1);
                else           chk("b2b_first", cyc, W + 1);
                last_done = cyc;
                ndone++;
                if (ndone < 3) begin
                    a = ops_a[ndone]; x = ops_x[ndone]; bin = ops_b[ndone];
                end else begin
                    start = 1'b0;
                end
            end else begin
                chk("b2b_busy_high", busy, 1);
            end
        end
        chk("b2b_count", ndone, 3);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle", busy, 0);

        // Reset in mid-RUN: the run is discarded
        run_op(4'b1000, 4'b0001, 1'b0, 0, "pre_rst");
        @(negedge clk);
        a = 4'b1111; x = 4'b0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_y", y, 0);
        chk("mrst_bout", bout, 0);
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) ok = 0;
        end
        chk("mrst_quiet", ok, 1);
        run_op(4'b0111, 4'b0010, 1'b1, 0, "post_rst");

        // Random operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), "rand");
        end

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_op(v[3:0], v[7:4], v[8], 0, "exh");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout obs=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
